// File: rtl/vga_timing_pkg.sv
// Shared 640x480 timing constants and tracker state encoding, used by the
// sync generator and by vga_sync_tracker.
package vga_timing_pkg;

  localparam int VGA_H_TOTAL      = 800;
  localparam int VGA_H_ACTIVE     = 640;
  localparam int VGA_H_SYNC_START = 656;
  localparam int VGA_V_TOTAL      = 525;
  localparam int VGA_V_ACTIVE     = 480;
  localparam int VGA_V_SYNC_START = 490;
  localparam int VGA_LOCK_FRAMES  = 2;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } trk_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Sample register plus falling-edge pulse for one active-low sync line.
// The register resets to 1 (idle) so a sync already low at release is a fresh edge.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_n,
  output logic fall
);

  logic smp;

  always_ff @(posedge clk) begin
    if (!rst_n) smp <= 1'b1;
    else        smp <= sync_n;
  end

  assign fall = smp & ~sync_n;

endmodule

// File: rtl/vga_sync_tracker.sv
// Recovers h/v pixel counters from an incoming sync pair, checks edge positions
// and reports lock/DE. Optional error statistics: VGA_SYNC_TRACK_STATS_EN.
module vga_sync_tracker
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL      = VGA_H_TOTAL,
  parameter int H_ACTIVE     = VGA_H_ACTIVE,
  parameter int H_SYNC_START = VGA_H_SYNC_START,
  parameter int V_TOTAL      = VGA_V_TOTAL,
  parameter int V_ACTIVE     = VGA_V_ACTIVE,
  parameter int V_SYNC_START = VGA_V_SYNC_START,
  parameter int LOCK_FRAMES  = VGA_LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_hsync,
  input  logic        i_vsync,
  output logic [9:0]  o_hcounter,
  output logic [9:0]  o_vcounter,
  output logic        o_locked,
  output logic        o_de,
  output logic        o_line_err,
  output logic        o_frame_err,
  output logic [15:0] o_err_count
);

  localparam int IDLE_W = $clog2(2*H_TOTAL+1);
  localparam int GOOD_W = $clog2(LOCK_FRAMES+1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(2*H_TOTAL);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_FRAMES);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL-1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL-1);
  localparam logic [9:0] H_SS   = 10'(H_SYNC_START);
  localparam logic [9:0] V_SS   = 10'(V_SYNC_START);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);

  logic hs_fall, vs_fall;

  sync_edge_detect u_hs (.clk(clk), .rst_n(i_rst_n), .sync_n(i_hsync), .fall(hs_fall));
  sync_edge_detect u_vs (.clk(clk), .rst_n(i_rst_n), .sync_n(i_vsync), .fall(vs_fall));

  trk_state_e        state, st_nxt;
  logic [GOOD_W-1:0] good, good_nxt;
  logic [IDLE_W-1:0] idle, idle_nxt;
  logic              dirty, dirty_nxt;
  logic              h_wrap, line_err_c, frame_err_c, err_c, timeout;
  logic [9:0]        h_pred, v_pred, h_nxt, v_nxt;

  always_comb begin
    h_wrap      = (o_hcounter == H_LAST);
    h_pred      = h_wrap ? 10'd0 : o_hcounter + 10'd1;
    v_pred      = h_wrap ? ((o_vcounter == V_LAST) ? 10'd0 : o_vcounter + 10'd1) : o_vcounter;
    h_nxt       = hs_fall ? H_SS : h_pred;
    v_nxt       = vs_fall ? V_SS : v_pred;
    line_err_c  = hs_fall && (state != SEARCH) && (h_pred != H_SS);
    frame_err_c = vs_fall && (state != SEARCH) && (v_pred != V_SS);
    err_c       = line_err_c | frame_err_c;
    idle_nxt    = hs_fall ? '0 : ((idle == IDLE_MAX) ? idle : idle + IDLE_W'(1));
    timeout     = (idle_nxt == IDLE_MAX);
    // dirty covers errors seen between vsync edges; the edge itself is judged first
    dirty_nxt   = vs_fall ? 1'b0 : (dirty | err_c);

    st_nxt   = state;
    good_nxt = good;
    case (state)
      SEARCH: if (vs_fall) begin
        st_nxt   = ACQUIRE;
        good_nxt = '0;
      end
      ACQUIRE: if (vs_fall) begin
        good_nxt = (err_c || dirty) ? '0 : good + GOOD_W'(1);
        if (good_nxt == GOOD_LOCK) st_nxt = LOCKED;
      end
      LOCKED: if (err_c) begin
        st_nxt   = ACQUIRE;
        good_nxt = '0;
      end
      default: st_nxt = SEARCH;
    endcase
    if (timeout) begin
      st_nxt   = SEARCH;
      good_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state       <= SEARCH;
      good        <= '0;
      idle        <= '0;
      dirty       <= 1'b0;
      o_hcounter  <= '0;
      o_vcounter  <= '0;
      o_locked    <= 1'b0;
      o_de        <= 1'b0;
      o_line_err  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= st_nxt;
      good        <= good_nxt;
      idle        <= idle_nxt;
      dirty       <= dirty_nxt;
      o_hcounter  <= h_nxt;
      o_vcounter  <= v_nxt;
      o_locked    <= (st_nxt == LOCKED);
      o_de        <= (st_nxt == LOCKED) && (h_nxt < H_ACT) && (v_nxt < V_ACT);
      o_line_err  <= line_err_c;
      o_frame_err <= frame_err_c;
    end
  end

`ifdef VGA_SYNC_TRACK_STATS_EN
  logic [15:0] err_cnt;

  always_ff @(posedge clk) begin
    if (!i_rst_n)
      err_cnt <= '0;
    else if ((o_line_err || o_frame_err) && (err_cnt != 16'hFFFF))
      err_cnt <= err_cnt + 16'd1;
  end

  assign o_err_count = err_cnt;
`else
  assign o_err_count = '0;
`endif

endmodule

// File: tb/tb_vga_sync_tracker.sv
// Bench for vga_sync_tracker on a scaled 40x20 timing so full lock sequences
// fit a short run; a sync generator drives the DUT and an event model predicts it.
module tb_vga_sync_tracker;

  localparam int HT = 40, HA = 32, HSS = 38;
  localparam int VT = 20, VA = 16, VSS = 17;
  localparam int LF = 2;
  localparam int FRAME = HT * VT;
  localparam int S_SEARCH = 0, S_ACQ = 1, S_LOCK = 2;
`ifdef VGA_SYNC_TRACK_STATS_EN
  localparam int EXP3 = 3;
`else
  localparam int EXP3 = 0;
`endif

  logic        clk, rst_n, hsync, vsync;
  logic [9:0]  o_hcounter, o_vcounter;
  logic        o_locked, o_de, o_line_err, o_frame_err;
  logic [15:0] o_err_count;

  vga_sync_tracker #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS),
    .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .i_rst_n(rst_n), .i_hsync(hsync), .i_vsync(vsync),
    .o_hcounter(o_hcounter), .o_vcounter(o_vcounter), .o_locked(o_locked),
    .o_de(o_de), .o_line_err(o_line_err), .o_frame_err(o_frame_err),
    .o_err_count(o_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: inputs as sampled at each rising edge ----------------
  logic smp_h, smp_v, smp_r;
  always @(posedge clk) begin
    smp_h <= hsync;
    smp_v <= vsync;
    smp_r <= rst_n;
  end

  int m_h, m_v, m_st, m_good, m_idle, m_cnt;
  bit m_dirty, m_hp, m_vp, m_le, m_fe, m_lock, m_de, m_valid = 0;

  always @(negedge clk) begin : mdl
    int ph, pv;
    bit hf, vf, le, fe, er;
    if (smp_r === 1'b0) begin
      m_h = 0; m_v = 0; m_st = S_SEARCH; m_good = 0; m_idle = 0; m_cnt = 0;
      m_dirty = 0; m_hp = 1; m_vp = 1; m_le = 0; m_fe = 0; m_lock = 0; m_de = 0;
      m_valid = 1;
    end else if (m_valid) begin
`ifdef VGA_SYNC_TRACK_STATS_EN
      if ((m_le || m_fe) && m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
      hf = m_hp && !smp_h;
      vf = m_vp && !smp_v;
      m_hp = smp_h;
      m_vp = smp_v;
      ph = (m_h + 1) % HT;
      pv = (ph == 0) ? (m_v + 1) % VT : m_v;
      le = hf && m_st != S_SEARCH && ph != HSS;
      fe = vf && m_st != S_SEARCH && pv != VSS;
      er = le || fe;
      if (m_st == S_SEARCH && vf) begin
        m_st = S_ACQ; m_good = 0;
      end else if (m_st == S_ACQ && vf) begin
        m_good = (er || m_dirty) ? 0 : m_good + 1;
        if (m_good >= LF) m_st = S_LOCK;
      end else if (m_st == S_LOCK && er) begin
        m_st = S_ACQ; m_good = 0;
      end
      m_dirty = vf ? 1'b0 : (m_dirty || er);
      m_idle = hf ? 0 : ((m_idle < 2*HT) ? m_idle + 1 : m_idle);
      if (m_idle >= 2*HT) begin
        m_st = S_SEARCH; m_good = 0;
      end
      m_h = hf ? HSS : ph;
      m_v = vf ? VSS : pv;
      m_le = le;
      m_fe = fe;
      m_lock = (m_st == S_LOCK);
      m_de = m_lock && m_h < HA && m_v < VA;
    end
    if (m_valid) begin
      chk("hcounter", o_hcounter, m_h);
      chk("vcounter", o_vcounter, m_v);
      chk("locked", o_locked, m_lock);
      chk("de", o_de, m_de);
      chk("line_err", o_line_err, m_le);
      chk("frame_err", o_frame_err, m_fe);
      chk("err_count", o_err_count, m_cnt);
    end
  end

  // ---------------- generator / directed stimulus ----------------
  int gen_h = 0, gen_v = 0, gen_len = HT;
  bit hold_h = 0, storm = 0, storm_t = 0;
  bit d_hs = 1, d_vs = 1, p_hs = 1, p_vs = 1, h_edge, v_edge;
  int n_le = 0, n_fe = 0;

  task automatic step();
    @(negedge clk);
    h_edge = p_hs && !d_hs;
    v_edge = p_vs && !d_vs;
    n_le += int'(o_line_err);
    n_fe += int'(o_frame_err);
    p_hs = d_hs;
    p_vs = d_vs;
    if (storm) begin
      storm_t = !storm_t;
      d_hs = storm_t;
      d_vs = !storm_t;
    end else begin
      d_hs = hold_h || !(gen_h >= HSS && gen_h < HSS + 2);
      d_vs = !(gen_v >= VSS && gen_v < VSS + 2);
    end
    hsync = d_hs;
    vsync = d_vs;
    if (gen_h >= gen_len - 1) begin
      gen_h = 0; gen_len = HT; gen_v = (gen_v + 1) % VT;
    end else gen_h++;
  endtask

  task automatic relock_check(input string nm);
    int ve = 0, n = 0;
    while (ve < 3 && n < 5*FRAME) begin
      step(); n++;
      if (v_edge) begin
        ve++;
        if (ve == 2) chk({nm, "_early"}, o_locked, 0);
        if (ve == 3) begin
          chk({nm, "_rise"}, o_locked, 1);
          chk({nm, "_valign"}, o_vcounter, VSS);
        end
      end
    end
    if (ve < 3) chk({nm, "_bound"}, ve, 3);
  endtask

  task automatic wait_gen(input int h, input int v);
    int n = 0;
    while (!(gen_h == h && gen_v == v) && n < 3*FRAME) begin step(); n++; end
  endtask

  initial begin : drv
    int n, de_cnt, err_cnt;
    bit h_seen;
    rst_n = 0; hsync = 1; vsync = 1;
    repeat (3) step();
    chk("rst_h", o_hcounter, 0);
    chk("rst_lock", o_locked, 0);
    chk("rst_cnt", o_err_count, 0);
    rst_n = 1;

    // clean stream: lock on 3rd vsync edge, then one locked frame
    relock_check("clean");
    de_cnt = 0; n = 0; h_seen = 0; n_le = 0; n_fe = 0;
    do begin
      step(); n++;
      de_cnt += int'(o_de);
      if (h_edge && !h_seen) begin
        chk("h_align", o_hcounter, HSS);
        h_seen = 1;
      end
    end while (!v_edge && n < 2*FRAME);
    chk("de_frame", de_cnt, HA*VA);
    err_cnt = n_le + n_fe;
    chk("clean_err", err_cnt, 0);

    // one short line while locked
    wait_gen(0, 5);
    gen_len = HT - 1;
    n = 0;
    do begin step(); n++; end while (!o_line_err && n < 3*HT);
    chk("short_err", o_line_err, 1);
    chk("short_unlock", o_locked, 0);
    relock_check("short");

    // hsync stuck high: timeout after 2*HT clocks
    n = 0;
    do begin step(); n++; end while (!h_edge && n < 2*HT);
    hold_h = 1;
    for (int k = 1; k <= 2*HT; k++) begin
      step();
      if (k == 2*HT-1) chk("to_before", o_locked, 1);
      if (k == 2*HT) begin
        chk("to_lock", o_locked, 0);
        chk("to_de", o_de, 0);
      end
    end
    hold_h = 0;
    n = 0;
    while (!o_locked && n < 5*FRAME) begin step(); n++; end
    chk("to_relock", o_locked, 1);

    // reset mid-line while locked
    wait_gen(10, 5);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("mrst_h", o_hcounter, 0);
    chk("mrst_v", o_vcounter, 0);
    chk("mrst_lock", o_locked, 0);
    chk("mrst_de", o_de, 0);
    chk("mrst_le", o_line_err, 0);
    chk("mrst_fe", o_frame_err, 0);
    chk("mrst_cnt", o_err_count, 0);
    relock_check("mrst");

    // three injected errors: short line, skipped line, short line
    n_le = 0; n_fe = 0;
    wait_gen(0, 5);
    gen_len = HT - 1;
    wait_gen(0, 10);
    gen_v = 11;
    wait_gen(0, 5);
    gen_len = HT - 1;
    repeat (3*HT) step();
    chk("inj_line", n_le, 2);
    chk("inj_frame", n_fe, 1);
    chk("inj_count", o_err_count, EXP3);

`ifdef VGA_SYNC_TRACK_STATS_EN
    // alternating hsync/vsync edges give an error pulse on every clock
    storm = 1;
    repeat (66000) step();
    chk("sat", o_err_count, 16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

endmodule
